memory_word_sequencer: RTL and testbench

- Memory-side counterpart of the address register file: consumes a 16-bit address (ARF OutD, i.e. PC/AR/SP) and performs one 16-bit word transfer against byte-wide synchronous memory.
- A read or write takes two byte accesses at Address and Address+1.
- Sits between the ARF/control unit and the instruction/data memory.
- Exposes a Start/Busy/Done handshake to the control FSM.

---
 rtl/memory_word_sequencer_if.sv | 29 ++
 rtl/memory_word_sequencer.sv | 169 ++++++++++++++++
 tb/tb_memory_word_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_word_sequencer_if.sv
// Word-transfer bus between the control side and the memory word sequencer,
// together with the byte-wide memory port that the sequencer drives.
`timescale 1ns/1ps
interface memory_word_sequencer_if;
  logic        start;
  logic        write;
  logic [15:0] address;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        mem_cs;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;

  // Environment side: control FSM plus the byte memory.
  modport master (
    output start, write, address, wdata, mem_data_in,
    input  rdata, busy, done, mem_cs, mem_wr, mem_addr, mem_data_out
  );

  // Sequencer side.
  modport slave (
    input  start, write, address, wdata, mem_data_in,
    output rdata, busy, done, mem_cs, mem_wr, mem_addr, mem_data_out
  );
endinterface

// File: rtl/memory_word_sequencer.sv
// Memory word sequencer: turns one 16-bit word read/write request into two
// byte accesses at address and address+1 on a byte-wide synchronous memory.
//
// state  | meaning
// IDLE   | waiting for start; request fields latched on accept
// ACC_LO | first byte access (base address)
// ACC_HI | second byte access (base address + 1, wraps at 16 bits)
// DRAIN  | read only: waiting MEM_LATENCY cycles for read bytes to return
// DONE   | one-cycle done pulse; start not accepted here
`timescale 1ns/1ps
module memory_word_sequencer #(
  parameter bit          LITTLE_ENDIAN = 1'b1,
  parameter int unsigned MEM_LATENCY   = 1
) (
  input logic                     clock,
  input logic                     reset,
  memory_word_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_LO = 3'd1,
    ACC_HI = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Drain counter counts down from MEM_LATENCY-1; terminal count 0 ends DRAIN.
  localparam logic [1:0] DRAIN_LOAD = 2'(MEM_LATENCY - 1);
  localparam bit         LAT_ONE    = (MEM_LATENCY == 1);

  state_t      state;
  state_t      next_state;

  logic        write_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  byte_first;
  logic [1:0]  drain_cnt;

  logic [15:0] rdata_q;
  logic        busy_q;
  logic        done_q;
  logic        cs_q;
  logic        wr_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  dout_q;

  logic        cs_n;
  logic        wr_n;
  logic        busy_n;
  logic        done_n;
  logic [15:0] mem_addr_n;
  logic [7:0]  dout_n;

  logic        sample_first;
  logic        sample_second;

  // The byte from the base address lands MEM_LATENCY cycles after ACC_LO,
  // the second byte exactly when the drain counter reaches terminal count.
  assign sample_first  = (state == ACC_HI && LAT_ONE) ||
                         (state == DRAIN && drain_cnt == 2'd1);
  assign sample_second = (state == DRAIN && drain_cnt == 2'd0);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    next_state = state;
    cs_n       = 1'b0;
    wr_n       = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    mem_addr_n = mem_addr_q;
    dout_n     = dout_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = ACC_LO;
          cs_n       = 1'b1;
          wr_n       = bus.write;
          busy_n     = 1'b1;
          mem_addr_n = bus.address;
          dout_n     = LITTLE_ENDIAN ? bus.wdata[7:0] : bus.wdata[15:8];
        end
      end
      ACC_LO: begin
        next_state = ACC_HI;
        cs_n       = 1'b1;
        wr_n       = write_q;
        busy_n     = 1'b1;
        mem_addr_n = addr_q + 16'd1;
        dout_n     = LITTLE_ENDIAN ? wdata_q[15:8] : wdata_q[7:0];
      end
      ACC_HI: begin
        if (write_q) begin
          next_state = DONE;
          done_n     = 1'b1;
        end else begin
          next_state = DRAIN;
          busy_n     = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == 2'd0) begin
          next_state = DONE;
          done_n     = 1'b1;
        end else begin
          busy_n     = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output registers, request latches, drain counter and read assembly.
  always_ff @(posedge clock) begin
    if (!reset) begin
      write_q    <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      byte_first <= 8'h00;
      drain_cnt  <= 2'd0;
      rdata_q    <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      mem_addr_q <= 16'h0000;
      dout_q     <= 8'h00;
    end else begin
      busy_q     <= busy_n;
      done_q     <= done_n;
      cs_q       <= cs_n;
      wr_q       <= wr_n;
      mem_addr_q <= mem_addr_n;
      dout_q     <= dout_n;
      if (state == IDLE && bus.start) begin
        write_q <= bus.write;
        addr_q  <= bus.address;
        wdata_q <= bus.wdata;
      end
      if (state == ACC_HI)
        drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN && drain_cnt != 2'd0)
        drain_cnt <= drain_cnt - 2'd1;
      if (sample_first)
        byte_first <= bus.mem_data_in;
      // Second byte goes straight into the word so it is visible in DONE.
      if (sample_second)
        rdata_q <= LITTLE_ENDIAN ? {bus.mem_data_in, byte_first}
                                 : {byte_first, bus.mem_data_in};
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mem_cs       = cs_q;
  assign bus.mem_wr       = wr_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_out = dout_q;

endmodule

// File: tb/tb_memory_word_sequencer.sv
// Bench for memory_word_sequencer: two instances (latency 1 little-endian,
// latency 3 big-endian) share one stimulus stream, each with its own memory.
`timescale 1ns/1ps
module tb_memory_word_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  memory_word_sequencer_if bus_a ();
  memory_word_sequencer_if bus_b ();

  memory_word_sequencer #(.LITTLE_ENDIAN(1'b1), .MEM_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );
  memory_word_sequencer #(.LITTLE_ENDIAN(1'b0), .MEM_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  assign bus_b.start   = bus_a.start;
  assign bus_b.write   = bus_a.write;
  assign bus_b.address = bus_a.address;
  assign bus_b.wdata   = bus_a.wdata;

  // Byte memories; unread cycles return a marker byte.
  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];
  logic [7:0] rd_a, p1_b, p2_b, p3_b;

  always @(posedge clock) begin
    if (bus_a.mem_cs && bus_a.mem_wr) mem_a[bus_a.mem_addr] <= bus_a.mem_data_out;
    rd_a <= (bus_a.mem_cs && !bus_a.mem_wr) ? mem_a[bus_a.mem_addr] : 8'hA5;
  end
  assign bus_a.mem_data_in = rd_a;

  always @(posedge clock) begin
    if (bus_b.mem_cs && bus_b.mem_wr) mem_b[bus_b.mem_addr] <= bus_b.mem_data_out;
    p1_b <= (bus_b.mem_cs && !bus_b.mem_wr) ? mem_b[bus_b.mem_addr] : 8'h5A;
    p2_b <= p1_b;
    p3_b <= p2_b;
  end
  assign bus_b.mem_data_in = p3_b;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {int cyc; logic [15:0] rdata;} done_t;
  typedef struct {int cyc; logic wr; logic [15:0] addr; logic [7:0] data;} acc_t;
  done_t dq [2][$];
  acc_t  aq [2][$];

  logic [1:0]  m_done, m_cs, m_wr, m_busy;
  logic [15:0] m_rdata [2];
  logic [15:0] m_addr  [2];
  logic [7:0]  m_dout  [2];
  assign m_done = {bus_b.done, bus_a.done};
  assign m_cs   = {bus_b.mem_cs, bus_a.mem_cs};
  assign m_wr   = {bus_b.mem_wr, bus_a.mem_wr};
  assign m_busy = {bus_b.busy, bus_a.busy};
  assign m_rdata[0] = bus_a.rdata;
  assign m_rdata[1] = bus_b.rdata;
  assign m_addr[0]  = bus_a.mem_addr;
  assign m_addr[1]  = bus_b.mem_addr;
  assign m_dout[0]  = bus_a.mem_data_out;
  assign m_dout[1]  = bus_b.mem_data_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expected accesses and completions as the DUTs present them.
  done_t e_done;
  acc_t  e_acc;
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (m_wr[d]) check($sformatf("dut%0d_wr_without_cs", d), 64'(m_cs[d]), 64'd1);
      if (m_done[d]) begin
        if (dq[d].size() == 0) begin
          total++; bad++;
          $display("FAIL dut%0d_spurious_done at cycle %0d: got done=1 expected none", d, cyc);
        end else begin
          e_done = dq[d].pop_front();
          check($sformatf("dut%0d_done_cycle", d), 64'(cyc), 64'(e_done.cyc));
          check($sformatf("dut%0d_rdata", d), 64'(m_rdata[d]), 64'(e_done.rdata));
          check($sformatf("dut%0d_busy_in_done", d), 64'(m_busy[d]), 64'd0);
        end
      end
      if (m_cs[d]) begin
        if (aq[d].size() == 0) begin
          total++; bad++;
          $display("FAIL dut%0d_spurious_access at cycle %0d: got mem_cs=1 addr=%0h expected none",
                   d, cyc, m_addr[d]);
        end else begin
          e_acc = aq[d].pop_front();
          check($sformatf("dut%0d_acc_cycle", d), 64'(cyc), 64'(e_acc.cyc));
          check($sformatf("dut%0d_acc_wr", d), 64'(m_wr[d]), 64'(e_acc.wr));
          check($sformatf("dut%0d_acc_addr", d), 64'(m_addr[d]), 64'(e_acc.addr));
          check($sformatf("dut%0d_acc_data", d), 64'(m_dout[d]), 64'(e_acc.data));
          check($sformatf("dut%0d_busy_in_acc", d), 64'(m_busy[d]), 64'd1);
        end
      end
    end
  end

  // Issues one request and records the accesses and completion it must cause.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input bit expect_done);
    acc_t  a;
    done_t dn;
    int    c;
    @(negedge clock);
    c = cyc;
    bus_a.start   = 1'b1;
    bus_a.write   = wr;
    bus_a.address = addr;
    bus_a.wdata   = wd;
    for (int d = 0; d < 2; d++) begin
      a.wr   = wr;
      a.cyc  = c + 1;
      a.addr = addr;
      a.data = (d == 0) ? wd[7:0] : wd[15:8];
      aq[d].push_back(a);
      a.cyc  = c + 2;
      a.addr = addr + 16'd1;
      a.data = (d == 0) ? wd[15:8] : wd[7:0];
      aq[d].push_back(a);
      if (expect_done) begin
        dn.cyc   = wr ? c + 3 : c + 3 + ((d == 0) ? 1 : 3);
        dn.rdata = exp_rd;
        dq[d].push_back(dn);
      end
    end
    @(negedge clock);
    bus_a.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.start   = 1'b1;
    bus_a.write   = 1'b1;
    bus_a.address = 16'h5555;
    bus_a.wdata   = 16'h5555;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    bus_a.start = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("idle_outputs_a", {20'd0, bus_a.busy, bus_a.done, bus_a.mem_cs, bus_a.mem_wr,
            bus_a.rdata, bus_a.mem_addr, bus_a.mem_data_out}, 64'd0);
      check("idle_outputs_b", {20'd0, bus_b.busy, bus_b.done, bus_b.mem_cs, bus_b.mem_wr,
            bus_b.rdata, bus_b.mem_addr, bus_b.mem_data_out}, 64'd0);
    end

    issue(1'b1, 16'h0100, 16'hBEEF, 16'h0000, 1'b1);
    repeat (6) @(negedge clock);
    check("mem_a_0100", 64'(mem_a[16'h0100]), 64'hEF);
    check("mem_a_0101", 64'(mem_a[16'h0101]), 64'hBE);
    check("mem_b_0100", 64'(mem_b[16'h0100]), 64'hBE);
    check("mem_b_0101", 64'(mem_b[16'h0101]), 64'hEF);

    issue(1'b0, 16'h0100, 16'h0000, 16'hBEEF, 1'b1);
    repeat (8) @(negedge clock);

    issue(1'b1, 16'hFFFF, 16'h1234, 16'hBEEF, 1'b1);
    repeat (6) @(negedge clock);
    check("mem_a_ffff", 64'(mem_a[16'hFFFF]), 64'h34);
    check("mem_a_0000", 64'(mem_a[16'h0000]), 64'h12);
    check("mem_b_ffff", 64'(mem_b[16'hFFFF]), 64'h12);
    check("mem_b_0000", 64'(mem_b[16'h0000]), 64'h34);

    issue(1'b0, 16'hFFFF, 16'h0000, 16'h1234, 1'b1);
    repeat (8) @(negedge clock);

    // Start held through ACC_LO, ACC_HI and DONE of a write must be ignored.
    issue(1'b1, 16'h0200, 16'hCAFE, 16'h1234, 1'b1);
    bus_a.start   = 1'b1;
    bus_a.write   = 1'b1;
    bus_a.address = 16'h0300;
    bus_a.wdata   = 16'h1111;
    @(negedge clock);
    check("busy_a_acc_hi", 64'(bus_a.busy), 64'd1);
    check("busy_b_acc_hi", 64'(bus_b.busy), 64'd1);
    @(negedge clock);
    issue(1'b0, 16'h0200, 16'h0000, 16'hCAFE, 1'b1);
    repeat (8) @(negedge clock);

    // Reset during a read's DRAIN aborts without a done pulse.
    issue(1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("busy_a_drain", 64'(bus_a.busy), 64'd1);
    check("busy_b_drain", 64'(bus_b.busy), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    check("abort_a", {44'd0, bus_a.busy, bus_a.done, bus_a.mem_cs, bus_a.mem_wr, bus_a.rdata},
          64'd0);
    check("abort_b", {44'd0, bus_b.busy, bus_b.done, bus_b.mem_cs, bus_b.mem_wr, bus_b.rdata},
          64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    issue(1'b0, 16'hFFFF, 16'h0000, 16'h1234, 1'b1);
    repeat (8) @(negedge clock);
    issue(1'b1, 16'h0400, 16'h0A0B, 16'h1234, 1'b1);
    repeat (6) @(negedge clock);

    check("pending_done", 64'(dq[0].size() + dq[1].size()), 64'd0);
    check("pending_access", 64'(aq[0].size() + aq[1].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
